// File: rtl/hawk_phase_sequencer.sv
// HAWK pedestrian beacon sequencer with its own tick prescaler and phase timer.
// Define HAWK_COUNTDOWN_EN to add the ped_count clearance countdown output.
module hawk_phase_sequencer #(
    parameter int TICK_DIV   = 25000000,
    parameter int T_FLASH_Y  = 8,
    parameter int T_STEADY_Y = 8,
    parameter int T_WALK     = 14,
    parameter int T_CLEAR    = 30,
    parameter int T_LOCKOUT  = 20,
    parameter int TW         = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          ped_call,
    output logic          bcn_yel,
    output logic          bcn_red_l,
    output logic          bcn_red_r,
    output logic          walk,
    output logic          dnw,
    output logic          call_pending,
    output logic [2:0]    state
`ifdef HAWK_COUNTDOWN_EN
    ,
    output logic [TW-1:0] ped_count
`endif
);

    localparam int PW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [TW-1:0] LD_FLASH_Y  = TW'(T_FLASH_Y - 1);
    localparam logic [TW-1:0] LD_STEADY_Y = TW'(T_STEADY_Y - 1);
    localparam logic [TW-1:0] LD_WALK     = TW'(T_WALK - 1);
    localparam logic [TW-1:0] LD_CLEAR    = TW'(T_CLEAR - 1);
    localparam logic [TW-1:0] LD_LOCKOUT  = TW'(T_LOCKOUT - 1);

    typedef enum logic [2:0] {
        S_DARK     = 3'd0,
        S_FLASH_Y  = 3'd1,
        S_STEADY_Y = 3'd2,
        S_WALK     = 3'd3,
        S_CLEAR    = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          flash_q, flash_d;
    logic          call_q, call_d;

    logic tick;
    logic expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_DARK;
            presc_q <= '0;
            timer_q <= '0;
            flash_q <= 1'b0;
            call_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            flash_q <= flash_d;
            call_q  <= call_d;
        end
    end

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        expire  = tick && (timer_q == '0);
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        timer_d = tick ? timer_q - 1'b1 : timer_q;
        flash_d = flash_q;
        call_d  = call_q | (ped_call && (state_q != S_WALK));

        case (state_q)
            S_DARK: begin
                timer_d = timer_q;
                // Entering FLASH_Y consumes the call, even if ped_call is still high.
                if (call_q) begin
                    state_d = S_FLASH_Y;
                    presc_d = '0;
                    timer_d = LD_FLASH_Y;
                    flash_d = 1'b0;
                    call_d  = 1'b0;
                end
            end
            S_FLASH_Y: begin
                if (tick) flash_d = ~flash_q;
                if (expire) begin
                    state_d = S_STEADY_Y;
                    presc_d = '0;
                    timer_d = LD_STEADY_Y;
                end
            end
            S_STEADY_Y: begin
                if (expire) begin
                    state_d = S_WALK;
                    presc_d = '0;
                    timer_d = LD_WALK;
                end
            end
            S_WALK: begin
                if (expire) begin
                    state_d = S_CLEAR;
                    presc_d = '0;
                    timer_d = LD_CLEAR;
                    flash_d = 1'b0;
                end
            end
            S_CLEAR: begin
                if (tick) flash_d = ~flash_q;
                if (expire) begin
                    state_d = S_LOCKOUT;
                    presc_d = '0;
                    timer_d = LD_LOCKOUT;
                end
            end
            S_LOCKOUT: begin
                if (expire) begin
                    state_d = S_DARK;
                    presc_d = '0;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_DARK;
                presc_d = '0;
                timer_d = '0;
                flash_d = 1'b0;
                call_d  = call_q;
            end
        endcase

        // Maintenance mode behaves exactly like a held reset.
        if (!enable) begin
            state_d = S_DARK;
            presc_d = '0;
            timer_d = '0;
            flash_d = 1'b0;
            call_d  = 1'b0;
        end
    end

    always_comb begin
        bcn_yel   = 1'b0;
        bcn_red_l = 1'b0;
        bcn_red_r = 1'b0;
        walk      = 1'b0;
        dnw       = 1'b1;
        case (state_q)
            S_FLASH_Y: begin
                bcn_yel = ~flash_q;
            end
            S_STEADY_Y: begin
                bcn_yel = 1'b1;
            end
            S_WALK: begin
                bcn_red_l = 1'b1;
                bcn_red_r = 1'b1;
                walk      = 1'b1;
                dnw       = 1'b0;
            end
            S_CLEAR: begin
                bcn_red_l = ~flash_q;
                bcn_red_r = flash_q;
                dnw       = ~flash_q;
            end
            default: begin
            end
        endcase
    end

    assign state        = state_q;
    assign call_pending = call_q;

`ifdef HAWK_COUNTDOWN_EN
    assign ped_count = (state_q == S_CLEAR) ? timer_q + 1'b1 : '0;
`endif

    a_yel_red : assert property (@(posedge clk)
        !(bcn_yel && (bcn_red_l || bcn_red_r)));
    a_walk_dnw : assert property (@(posedge clk) !(walk && dnw));
    a_clear_one_red : assert property (@(posedge clk)
        (state_q == S_CLEAR) |-> !(bcn_red_l && bcn_red_r));

endmodule

// File: tb/tb_hawk_phase_sequencer.sv
// Randomized and directed bench for hawk_phase_sequencer against a
// per-cycle behavioural model of state, time-in-state and latched call.
module tb_hawk_phase_sequencer;

    localparam int TD  = 4;
    localparam int TFY = 4;
    localparam int TSY = 2;
    localparam int TWK = 3;
    localparam int TCL = 6;
    localparam int TLO = 5;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       enable   = 1'b1;
    logic       ped_call = 1'b0;
    logic       bcn_yel;
    logic       bcn_red_l;
    logic       bcn_red_r;
    logic       walk;
    logic       dnw;
    logic       call_pending;
    logic [2:0] state;
`ifdef HAWK_COUNTDOWN_EN
    logic [7:0] ped_count;
`endif

    int checks = 0;
    int errors = 0;

    int m_st   = 0;
    int m_cyc  = 0;
    bit m_call = 1'b0;

    hawk_phase_sequencer #(
        .TICK_DIV  (TD),
        .T_FLASH_Y (TFY),
        .T_STEADY_Y(TSY),
        .T_WALK    (TWK),
        .T_CLEAR   (TCL),
        .T_LOCKOUT (TLO),
        .TW        (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ped_call    (ped_call),
        .bcn_yel     (bcn_yel),
        .bcn_red_l   (bcn_red_l),
        .bcn_red_r   (bcn_red_r),
        .walk        (walk),
        .dnw         (dnw),
        .call_pending(call_pending),
        .state       (state)
`ifdef HAWK_COUNTDOWN_EN
        ,
        .ped_count   (ped_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic int dur(input int st);
        case (st)
            1:       return TFY * TD;
            2:       return TSY * TD;
            3:       return TWK * TD;
            4:       return TCL * TD;
            5:       return TLO * TD;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_step();
        bit nc;
        if (reset || !enable) begin
            m_st   = 0;
            m_cyc  = 0;
            m_call = 1'b0;
        end else begin
            nc = m_call | (ped_call && m_st != 3);
            if (m_st == 0) begin
                if (m_call) begin
                    m_st   = 1;
                    m_cyc  = 0;
                    m_call = 1'b0;
                end else begin
                    m_call = nc;
                end
            end else begin
                m_call = nc;
                if (m_cyc + 1 == dur(m_st)) begin
                    m_st  = (m_st == 5) ? 0 : m_st + 1;
                    m_cyc = 0;
                end else begin
                    m_cyc++;
                end
            end
        end
    endtask

    task automatic compare();
        logic [8:0] act_v;
        logic [8:0] exp_v;
        bit ph;
        bit yel, rl, rr, wk, dn;
        ph  = ((m_cyc / TD) % 2) == 1;
        yel = (m_st == 1) ? !ph : (m_st == 2);
        rl  = (m_st == 3) || (m_st == 4 && !ph);
        rr  = (m_st == 3) || (m_st == 4 && ph);
        wk  = (m_st == 3);
        dn  = (m_st == 4) ? !ph : (m_st != 3);
        exp_v = {3'(m_st), yel, rl, rr, wk, dn, m_call};
        act_v = {state, bcn_yel, bcn_red_l, bcn_red_r, walk, dnw,
                 call_pending};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs t=%0t: got %b expected %b", $time,
                     act_v, exp_v);
        end
`ifdef HAWK_COUNTDOWN_EN
        chk("ped_count", int'(ped_count),
            (m_st == 4) ? TCL - m_cyc / TD : 0);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic pulse();
        ped_call = 1'b1;
        cyc();
        ped_call = 1'b0;
    endtask

    task automatic run_until(input int tgt, input int budget, input string nm);
        int n = 0;
        while (int'(state) != tgt && n < budget) begin
            cyc();
            n++;
        end
        chk(nm, int'(state), tgt);
    endtask

    initial begin
        int n;

        // reset held 3 cycles
        repeat (3) cyc();
        chk("rst_state", int'(state), 0);
        chk("rst_dnw", int'(dnw), 1);
        chk("rst_call", int'(call_pending), 0);
        chk("rst_lamps", int'({bcn_yel, bcn_red_l, bcn_red_r, walk}), 0);
        reset = 1'b0;
        repeat (5) cyc();
        chk("idle_dark", int'(state), 0);

        // full cycle from a single pulse
        pulse();
        chk("latch_cp", int'(call_pending), 1);
        chk("latch_st", int'(state), 0);
        cyc();
        chk("fy_entry", int'(state), 1);
        chk("fy_cp_clr", int'(call_pending), 0);
        chk("fy_yel_on", int'(bcn_yel), 1);
        repeat (4) cyc();
        chk("fy_yel_off", int'(bcn_yel), 0);
        repeat (12) cyc();
        chk("sy_entry", int'(state), 2);
        repeat (8) cyc();
        chk("walk_entry", int'(state), 3);
        chk("walk_on", int'(walk), 1);
        repeat (12) cyc();
        chk("clr_entry", int'(state), 4);
        chk("clr_left", int'({bcn_red_l, bcn_red_r}), 2);
`ifdef HAWK_COUNTDOWN_EN
        chk("cnt_first", int'(ped_count), 6);
`endif
        repeat (4) cyc();
        chk("clr_right", int'({bcn_red_l, bcn_red_r}), 1);
`ifdef HAWK_COUNTDOWN_EN
        chk("cnt_second", int'(ped_count), 5);
`endif
        repeat (20) cyc();
        chk("lo_entry", int'(state), 5);
        repeat (20) cyc();
        chk("dark_ret", int'(state), 0);

        // call during WALK ignored
        repeat (3) cyc();
        pulse();
        run_until(3, 100, "to_walk");
        ped_call = 1'b1;
        repeat (5) cyc();
        ped_call = 1'b0;
        chk("walk_ignore", int'(call_pending), 0);
        run_until(0, 200, "to_dark");
        repeat (5) cyc();
        chk("idle_after", int'(state), 0);
        chk("idle_cp", int'(call_pending), 0);

        // call during CLEAR latched and served after DARK
        pulse();
        run_until(4, 200, "to_clear");
        pulse();
        chk("clr_latch", int'(call_pending), 1);
        run_until(0, 200, "to_dark2");
        cyc();
        chk("reserve", int'(state), 1);

        // ped_call held through LOCKOUT
        run_until(5, 200, "to_lock");
        ped_call = 1'b1;
        n = 1;
        while (state == 3'd5 && n < 100) begin
            cyc();
            if (state == 3'd5) n++;
        end
        ped_call = 1'b0;
        chk("lock_len", n, 20);

        // enable dropped mid-CLEAR
        run_until(4, 300, "to_clear2");
        repeat (5) cyc();
        enable = 1'b0;
        cyc();
        chk("en_dark", int'(state), 0);
        chk("en_cp", int'(call_pending), 0);
        chk("en_dnw", int'(dnw), 1);
        ped_call = 1'b1;
        repeat (3) cyc();
        ped_call = 1'b0;
        cyc();
        enable = 1'b1;
        repeat (10) cyc();
        chk("en_stay", int'(state), 0);

        // reset mid-WALK
        pulse();
        run_until(3, 100, "to_walk2");
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        chk("rw_state", int'(state), 0);
        chk("rw_walk", int'(walk), 0);
        chk("rw_dnw", int'(dnw), 1);
        reset = 1'b0;
        cyc();

        // randomized traffic
        repeat (4000) begin
            ped_call = ($urandom_range(0, 19) == 0);
            enable   = ($urandom_range(0, 299) != 0);
            reset    = ($urandom_range(0, 499) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
